bcd_seg_scan: RTL and testbench

//  Multiplexed seven-segment display driver for packed BCD digits.

---
 rtl/bcd_seg_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_seg_scan.sv | 118 +++++++++++
 tb/tb_bcd_seg_scan.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared segment patterns and BCD helpers for the multiplexed seven-segment driver.
package bcd_seg_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic bcd_is_valid(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decode table lookup
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed seven-segment scanner for NUM_DIGITS latched BCD nibbles.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    bcd_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    err_q, err_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    in_err_s;
  logic [3:0]              digit_s;
  logic [6:0]              dec_seg_s;
  logic                    blank_s;

  // Any non-BCD nibble on the incoming word
  always_comb begin
    in_err_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_err_s = in_err_s | ~bcd_is_valid(bcd_in[4*i +: 4]);
    end
  end

  assign digit_s = shadow_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (digit_s),
    .seg_o (dec_seg_s)
  );

`ifdef BCD_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lz_s;

  // lz_s[i] set when digit i and every more-significant digit are zero; digit 0 never blanks
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_s     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (shadow_q[4*i +: 4] == 4'd0);
      lz_s[i]  = zero_run;
    end
  end

  assign blank_s = lz_s[idx_q];
`else
  assign blank_s = 1'b0;
`endif

  // Next-state: shadow capture, refresh divider, digit index, output decode
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    div_d    = div_q;
    idx_d    = idx_q;
    if (load) begin
      shadow_d = bcd_in;
      err_d    = in_err_s;
    end else begin
      shadow_d = shadow_q;
      err_d    = err_q;
    end

    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end

    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank_s ? SEG_BLANK : dec_seg_s;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan: dut0 uses REFRESH_DIV=4, dut1 uses REFRESH_DIV=1.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst, load0, load1;
  logic [15:0] bcd0, bcd1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic        err0, err1;

  int vec  = 0;
  int miss = 0;
  int n    = 0;   // edges since reset was last sampled high

  always #5 clk = ~clk;

  bcd_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .load(load0), .bcd_in(bcd0),
    .seg(seg0), .an(an0), .bcd_err(err0)
  );

  bcd_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .bcd_in(bcd1),
    .seg(seg1), .an(an1), .bcd_err(err1)
  );

  // Displayed digit of dut0 after edge n is ((n-1)/4)%4; of dut1 it is (n-1)%4
  task automatic step();
    @(posedge clk);
    if (rst) n = 0;
    else     n = n + 1;
    #1;
  endtask

  // Advance dut0 to the first cycle of digit slot d
  task automatic align0(input int d);
    do step(); while (((n - 1) % 16) != 4 * d);
  endtask

  task automatic test_reset();
    rst = 1'b1; load0 = 1'b0; load1 = 1'b0; bcd0 = 16'h0000; bcd1 = 16'h0000;
    repeat (3) step();
    vec++; if (seg0 !== 7'h7F) begin miss++; $display("FAIL reset_seg got %h want 7f", seg0); end
    vec++; if (an0 !== 4'hF) begin miss++; $display("FAIL reset_an got %h want f", an0); end
    vec++; if (err0 !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", err0); end
    vec++; if (an1 !== 4'hF) begin miss++; $display("FAIL reset_an1 got %h want f", an1); end
    rst = 1'b0;
    step(); step();
    vec++; if (an0 !== 4'hE) begin miss++; $display("FAIL post_reset_an got %h want e", an0); end
    vec++; if (seg0 !== 7'h40) begin miss++; $display("FAIL post_reset_seg got %h want 40", seg0); end
    vec++; if (an1 !== 4'hD) begin miss++; $display("FAIL post_reset_an1 got %h want d", an1); end
  endtask

  task automatic test_scan();
    logic [3:0] an_t [4];
    logic [6:0] seg_t [4];
    an_t  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_t = '{7'h19, 7'h30, 7'h24, 7'h79};
    load0 = 1'b1; bcd0 = 16'h1234; step(); load0 = 1'b0;
    align0(0);
    for (int k = 0; k < 16; k++) begin
      vec++; if (an0 !== an_t[k/4]) begin miss++; $display("FAIL scan_an k=%0d got %h want %h", k, an0, an_t[k/4]); end
      vec++; if (seg0 !== seg_t[k/4]) begin miss++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg0, seg_t[k/4]); end
      step();
    end
    vec++; if (an0 !== 4'hE) begin miss++; $display("FAIL scan_wrap_an got %h want e", an0); end
    vec++; if (seg0 !== 7'h19) begin miss++; $display("FAIL scan_wrap_seg got %h want 19", seg0); end
  endtask

  task automatic test_bcd_err();
    vec++; if (err0 !== 1'b0) begin miss++; $display("FAIL err_before got %b want 0", err0); end
    load0 = 1'b1; bcd0 = 16'h12A4; step(); load0 = 1'b0;
    vec++; if (err0 !== 1'b1) begin miss++; $display("FAIL err_set got %b want 1", err0); end
    align0(1);
    vec++; if (an0 !== 4'hD) begin miss++; $display("FAIL err_dash_an got %h want d", an0); end
    vec++; if (seg0 !== 7'h3F) begin miss++; $display("FAIL err_dash_seg got %h want 3f", seg0); end
    align0(0);
    vec++; if (seg0 !== 7'h19) begin miss++; $display("FAIL err_d0_seg got %h want 19", seg0); end
    load0 = 1'b1; bcd0 = 16'h0000; step(); load0 = 1'b0;
    vec++; if (err0 !== 1'b0) begin miss++; $display("FAIL err_clear got %b want 0", err0); end
  endtask

  task automatic test_fast_wrap();
    logic [3:0] an_t [4];
    logic [6:0] seg_t [4];
    an_t  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_t = '{7'h00, 7'h78, 7'h02, 7'h12};
    while ((n % 4) != 3) step();
    load1 = 1'b1; bcd1 = 16'h5678; step(); load1 = 1'b0;
    vec++; if (an1 !== 4'h7) begin miss++; $display("FAIL fast_load_an got %h want 7", an1); end
    vec++; if (seg1 !== 7'h40) begin miss++; $display("FAIL fast_load_seg got %h want 40", seg1); end
    for (int k = 0; k < 6; k++) begin
      step();
      vec++; if (!$onehot(~an1)) begin miss++; $display("FAIL fast_onehot k=%0d got %h want one-hot low", k, an1); end
      vec++; if (an1 !== an_t[k%4]) begin miss++; $display("FAIL fast_an k=%0d got %h want %h", k, an1, an_t[k%4]); end
      vec++; if (seg1 !== seg_t[k%4]) begin miss++; $display("FAIL fast_seg k=%0d got %h want %h", k, seg1, seg_t[k%4]); end
    end
  endtask

  task automatic test_mid_reset();
    load0 = 1'b1; bcd0 = 16'h12A4; step(); load0 = 1'b0;
    while (((n / 4) % 4) != 2) step();
    rst = 1'b1; step();
    vec++; if (an0 !== 4'hF) begin miss++; $display("FAIL midrst_an got %h want f", an0); end
    vec++; if (seg0 !== 7'h7F) begin miss++; $display("FAIL midrst_seg got %h want 7f", seg0); end
    vec++; if (err0 !== 1'b0) begin miss++; $display("FAIL midrst_err got %b want 0", err0); end
    rst = 1'b0;
    step(); step();
    vec++; if (an0 !== 4'hE) begin miss++; $display("FAIL restart_an got %h want e", an0); end
    vec++; if (seg0 !== 7'h40) begin miss++; $display("FAIL restart_seg got %h want 40", seg0); end
    repeat (3) step();
    vec++; if (an0 !== 4'hD) begin miss++; $display("FAIL restart_d1_an got %h want d", an0); end
    vec++; if (seg0 !== 7'h40) begin miss++; $display("FAIL restart_d1_seg got %h want 40", seg0); end
  endtask

  task automatic test_lzb();
    logic [3:0] an_t [4];
    logic [6:0] e70 [4];
    logic [6:0] e00 [4];
    an_t = '{4'hE, 4'hD, 4'hB, 4'h7};
`ifdef BCD_SEG_LZB_EN
    e70 = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    e00 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    e70 = '{7'h40, 7'h78, 7'h40, 7'h40};
    e00 = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    load0 = 1'b1; bcd0 = 16'h0070; step(); load0 = 1'b0;
    align0(0);
    for (int k = 0; k < 4; k++) begin
      vec++; if (an0 !== an_t[k]) begin miss++; $display("FAIL lzb70_an k=%0d got %h want %h", k, an0, an_t[k]); end
      vec++; if (seg0 !== e70[k]) begin miss++; $display("FAIL lzb70_seg k=%0d got %h want %h", k, seg0, e70[k]); end
      repeat (4) step();
    end
    load0 = 1'b1; bcd0 = 16'h0000; step(); load0 = 1'b0;
    align0(0);
    for (int k = 0; k < 4; k++) begin
      vec++; if (seg0 !== e00[k]) begin miss++; $display("FAIL lzb00_seg k=%0d got %h want %h", k, seg0, e00[k]); end
      repeat (4) step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bcd_err();
    test_fast_wrap();
    test_mid_reset();
    test_lzb();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
